// File: rtl/barrel_pkg.sv
// Shared constants for the barrel shift arbiter: shift direction, output
// register state encoding and default widths.
package barrel_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SHW   = 3;
    localparam int DEF_IDW   = 2;

endpackage

// File: rtl/barrel_shifter_core.sv
// Combinational log-stage barrel shifter: one mux stage per shamt bit.
// Logical zero-fill shift by default; rotate when BARREL_ROTATE_EN is defined.
module barrel_shifter_core
    import barrel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    output logic [WIDTH-1:0] result
);

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] x,
                                                     input int amt,
                                                     input logic d);
        logic [WIDTH-1:0] r;
`ifdef BARREL_ROTATE_EN
        if (d == DIR_RIGHT) r = (x >> amt) | (x << (WIDTH - amt));
        else                r = (x << amt) | (x >> (WIDTH - amt));
`else
        if (d == DIR_RIGHT) r = x >> amt;
        else                r = x << amt;
`endif
        return r;
    endfunction

    always_comb begin
        logic [WIDTH-1:0] cur;
        cur = data;
        // Stage s moves by 2**s positions when shamt[s] is set
        for (int s = 0; s < SHW; s++) begin
            if (shamt[s]) cur = shift_step(cur, 1 << s, dir);
        end
        result = cur;
    end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters, with a
// single output register (full throughput). Rotate mode: define BARREL_ROTATE_EN.
module barrel_shift_arbiter
    import barrel_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW,
    parameter int IDW   = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SHW-1:0]   req_shamt,
    input  logic [NREQ-1:0]       req_dir,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant_idx;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_shamt;
    logic             sel_dir;
    logic [WIDTH-1:0] shifted;

    // Round-robin search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                found     = 1'b1;
                grant_idx = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign can_accept = (state_q == ST_EMPTY) || resp_ready;
    assign accept     = found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign sel_data  = req_data[grant_idx*WIDTH +: WIDTH];
    assign sel_shamt = req_shamt[grant_idx*SHW +: SHW];
    assign sel_dir   = req_dir[grant_idx];

    barrel_shifter_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .dir    (sel_dir),
        .result (shifted)
    );

    // A same-cycle drain and refill keeps the register FULL with no bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)          state_d = ST_FULL;
                else if (resp_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            ptr_q     <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                resp_data <= shifted;
                resp_id   <= grant_idx;
                ptr_q     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
            end
        end
    end

    assign resp_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed plus constrained-random bench for barrel_shift_arbiter with a
// reference arbiter/shifter model and a response scoreboard queue.
module tb_barrel_shift_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*SHW-1:0]   req_shamt;
    logic [NREQ-1:0]       req_dir;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic [IDW-1:0]        resp_id;

    barrel_shift_arbiter #(
        .NREQ (NREQ), .WIDTH (WIDTH), .SHW (SHW), .IDW (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_dir    (req_dir),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
    } resp_t;

    resp_t sb_q[$];
    resp_t exp_cur;
    int    total = 0;
    int    bad   = 0;
    int    m_ptr = 0;
    bit    m_full = 1'b0;
    bit    m_zero = 1'b0;
    int    last_grant = -1;

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                    input int sh, input logic dir);
        logic [WIDTH-1:0] r;
        int src;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            src = dir ? b + sh : b - sh;
`ifdef BARREL_ROTATE_EN
            r[b] = d[(src + WIDTH) % WIDTH];
`else
            r[b] = (src >= 0 && src < WIDTH) ? d[src] : 1'b0;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [WIDTH-1:0] d,
                           input int sh, input bit dir);
        req_valid[i]               = v;
        req_data[i*WIDTH +: WIDTH] = d;
        req_shamt[i*SHW +: SHW]    = SHW'(sh);
        req_dir[i]                 = dir;
    endtask

    // One clock: check grant before the edge, outputs 1ns after it
    task automatic cycle();
        int g;
        bit can;
        logic [NREQ-1:0] er;
        resp_t r;
        #3;
        g   = -1;
        can = !m_full || resp_ready;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        er = '0;
        if (!rst && g >= 0 && can) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        last_grant = -1;
        if (rst) begin
            sb_q.delete();
            m_ptr  = 0;
            m_full = 1'b0;
            m_zero = 1'b1;
        end else if (er != '0) begin
            r.data = ref_shift(req_data[g*WIDTH +: WIDTH], int'(req_shamt[g*SHW +: SHW]), req_dir[g]);
            r.id   = IDW'(g);
            sb_q.push_back(r);
            m_ptr      = (g + 1) % NREQ;
            m_full     = 1'b1;
            m_zero     = 1'b0;
            last_grant = g;
        end else if (resp_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        if (last_grant >= 0) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else exp_cur = sb_q.pop_front();
        end
        if (m_zero) exp_cur = '0;
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        if (m_full || m_zero) begin
            chk("resp_data", 32'(resp_data), 32'(exp_cur.data));
            chk("resp_id", 32'(resp_id), 32'(exp_cur.id));
        end
    endtask

    initial begin
        logic [IDW-1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst        = 1'b1;
        resp_ready = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_shamt  = '0;
        req_dir    = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // Idle after reset
        rst        = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("idle_valid", 32'(resp_valid), 32'd0);
            chk("idle_data", 32'(resp_data), 32'd0);
        end

        // Req0: 16 << 1
        set_req(0, 1'b1, 8'd16, 1, 1'b0);
        cycle();
        chk("req0_data", 32'(resp_data), 32'd32);
        chk("req0_id", 32'(resp_id), 32'd0);
        set_req(0, 1'b0, 8'd0, 0, 1'b0);

        // Req2: 4 >> 2
        set_req(2, 1'b1, 8'd4, 2, 1'b1);
        cycle();
        chk("req2_data", 32'(resp_data), 32'd1);
        chk("req2_id", 32'(resp_id), 32'd2);
        set_req(2, 1'b0, 8'd0, 0, 1'b0);

        // Req1: 0x81 left by 1, rotate vs. logical
        set_req(1, 1'b1, 8'h81, 1, 1'b0);
        cycle();
`ifdef BARREL_ROTATE_EN
        chk("msb_wrap", 32'(resp_data), 32'h03);
`else
        chk("msb_drop", 32'(resp_data), 32'h02);
`endif
        set_req(1, 1'b0, 8'd0, 0, 1'b0);

        // Shift by maximum amount, both directions
        set_req(3, 1'b1, 8'hA5, 7, 1'b1);
        cycle();
        set_req(3, 1'b1, 8'hA5, 7, 1'b0);
        cycle();
        set_req(3, 1'b0, 8'd0, 0, 1'b0);
        cycle();

        // Reset pointer, then all four requesters continuously
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'h31 << i, i + 1, i[0]);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("rr_id", 32'(resp_id), 32'(rr_seq[c]));
        end

        // Backpressure: result held, no grants, then no-bubble resume
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("hold_id", 32'(resp_id), 32'd0);
        end
        resp_ready = 1'b1;
        cycle();
        chk("resume_id", 32'(resp_id), 32'd1);

        // Reset while a result is pending and unconsumed
        resp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_drop", 32'(resp_valid), 32'd0);
        rst        = 1'b0;
        resp_ready = 1'b1;
        cycle();
        chk("post_rst_id", 32'(resp_id), 32'd0);

        // Random traffic; payload only changes when idle or just granted
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom),
                            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
